// File: rtl/microwave_countdown.sv
// Oven MM:SS countdown in BCD, stepped by the divider's 500 Hz wave.
// Start/pause/cancel control, magnetron enable and end-of-cook beeper.
module microwave_countdown #(
   parameter int TICKS_PER_SEC = 500,
   parameter int DONE_SECS     = 3
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       load,
   input  logic [3:0] set_m1,
   input  logic [3:0] set_m0,
   input  logic [3:0] set_s1,
   input  logic [3:0] set_s0,
   input  logic       start,
   input  logic       pause,
   input  logic       cancel,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       running,
   output logic       done,
   output logic [1:0] state
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = (DONE_SECS > 1) ? $clog2(DONE_SECS) : 1;
   localparam logic [CW-1:0] SUB_MAX = CW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0] SEC_MAX = SW'(DONE_SECS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q;
   logic [3:0]    m1_q, m0_q, s1_q, s0_q;
   logic [3:0]    m1_d, m0_d, s1_d, s0_d;
   logic [CW-1:0] sub_q;
   logic [SW-1:0] secs_q;
   logic          running_q, done_q;
   logic          sync1_q, sync2_q, prev_q;
   logic          tick_pulse, sec_step, last_sec, time_zero;

   function automatic logic [3:0] clamp(input logic [3:0] v,
                                        input logic [3:0] mx);
      return (v > mx) ? mx : v;
   endfunction

   assign tick_pulse = sync2_q & ~prev_q;
   assign sec_step   = tick_pulse && (sub_q == SUB_MAX);
   assign time_zero  = (m1_q == 4'd0) && (m0_q == 4'd0) &&
                       (s1_q == 4'd0) && (s0_q == 4'd0);
   assign last_sec   = (m1_q == 4'd0) && (m0_q == 4'd0) &&
                       (s1_q == 4'd0) && (s0_q == 4'd1);

   // Borrow chain: SS rolls 00 -> 59, MM borrows only when SS was 00.
   always_comb begin
      m1_d = m1_q;
      m0_d = m0_q;
      s1_d = s1_q;
      s0_d = s0_q;
      if (s0_q != 4'd0) begin
         s0_d = s0_q - 4'd1;
      end else begin
         s0_d = 4'd9;
         if (s1_q != 4'd0) begin
            s1_d = s1_q - 4'd1;
         end else begin
            s1_d = 4'd5;
            if (m0_q != 4'd0) begin
               m0_d = m0_q - 4'd1;
            end else begin
               m0_d = 4'd9;
               m1_d = m1_q - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= tick_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset || cancel) begin
         state_q   <= IDLE;
         m1_q      <= 4'd0;
         m0_q      <= 4'd0;
         s1_q      <= 4'd0;
         s0_q      <= 4'd0;
         sub_q     <= '0;
         secs_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (!time_zero) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                     sub_q     <= '0;
                  end
               end else if (load) begin
                  m1_q <= clamp(set_m1, 4'd9);
                  m0_q <= clamp(set_m0, 4'd9);
                  s1_q <= clamp(set_s1, 4'd5);
                  s0_q <= clamp(set_s0, 4'd9);
               end
            end
            RUN: begin
               if (pause) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end else if (sec_step) begin
                  sub_q <= '0;
                  m1_q  <= m1_d;
                  m0_q  <= m0_d;
                  s1_q  <= s1_d;
                  s0_q  <= s0_d;
                  if (last_sec) begin
                     state_q   <= DONE;
                     running_q <= 1'b0;
                     done_q    <= 1'b1;
                     secs_q    <= '0;
                  end
               end else if (tick_pulse) begin
                  sub_q <= sub_q + 1'b1;
               end
            end
            PAUSE: begin
               if (start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            DONE: begin
               if (sec_step) begin
                  sub_q <= '0;
                  if (secs_q == SEC_MAX) begin
                     state_q <= IDLE;
                     done_q  <= 1'b0;
                     secs_q  <= '0;
                  end else begin
                     secs_q <= secs_q + 1'b1;
                  end
               end else if (tick_pulse) begin
                  sub_q <= sub_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m1      = m1_q;
   assign m0      = m0_q;
   assign s1      = s1_q;
   assign s0      = s0_q;
   assign running = running_q;
   assign done    = done_q;
   assign state   = state_q;

endmodule
